// File: rtl/mem_io_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_io_bus_pkg
// Shared constants for the mem_io_bus slave:
//   - byte addresses of the I/O registers (all live at Address[31] = 1)
//   - STATUS bit indices and CLR bit indices
//   - TIMER_CMP reset value
//   - io_sel_t register-select type and the io_decode helper
// No ports (package).
// ----------------------------------------------------------------------------
package mem_io_bus_pkg;

    localparam logic [31:0] ADDR_TIMER_CNT = 32'h8000_0000;
    localparam logic [31:0] ADDR_TIMER_CMP = 32'h8000_0004;
    localparam logic [31:0] ADDR_STATUS    = 32'h8000_0008;
    localparam logic [31:0] ADDR_TX_DATA   = 32'h8000_000C;
    localparam logic [31:0] ADDR_CLR       = 32'h8000_0010;

    // STATUS bit positions; fifo_count occupies [15:8]
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_MATCH   = 2;
    localparam int ST_TX_OVF  = 3;
    localparam int ST_BUS_ERR = 4;

    // CLR (write-one-to-clear) bit positions, aligned with STATUS
    localparam int CLR_MATCH   = 2;
    localparam int CLR_TX_OVF  = 3;
    localparam int CLR_BUS_ERR = 4;

    localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IO_UNMAPPED  = 3'd0,
        IO_TIMER_CNT = 3'd1,
        IO_TIMER_CMP = 3'd2,
        IO_STATUS    = 3'd3,
        IO_TX_DATA   = 3'd4,
        IO_CLR       = 3'd5
    } io_sel_t;

    // Decode a word address (Address[31:2]) into an I/O register select.
    // Anything that is not one of the five registers is IO_UNMAPPED.
    function automatic io_sel_t io_decode(input logic [29:0] word_addr);
        io_sel_t sel;
        case (word_addr)
            ADDR_TIMER_CNT[31:2]: sel = IO_TIMER_CNT;
            ADDR_TIMER_CMP[31:2]: sel = IO_TIMER_CMP;
            ADDR_STATUS[31:2]:    sel = IO_STATUS;
            ADDR_TX_DATA[31:2]:   sel = IO_TX_DATA;
            ADDR_CLR[31:2]:       sel = IO_CLR;
            default:              sel = IO_UNMAPPED;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_io_bus_tx_fifo.sv
// ----------------------------------------------------------------------------
// mem_io_bus_tx_fifo
// Synchronous FIFO feeding the UART TX stream.
//   clk, reset (async active-low)
//   i_push / i_data : write request; accepted when not full, or when full
//                     and a pop happens in the same cycle
//   i_pop           : read request; takes effect only when not empty
//   o_data          : head entry (0 while empty), driven from registers only
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module mem_io_bus_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    assign w_pop  = i_pop && !o_empty;
    // When full, a same-cycle pop frees the slot the write pointer sits on.
    assign w_push = i_push && (!o_full || w_pop);

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_bus.sv
// ----------------------------------------------------------------------------
// mem_io_bus
// Memory/I/O slave on the multicycle RISC-V core's unified port.
//   clk         system clock, rising edge
//   reset       asynchronous, active-low
//   Address     byte address (bits [1:0] ignored, word access only)
//   Write_Data  store data
//   Mem_Write   store strobe, one write per cycle
//   Read_Data   combinational read data for Address
//   tx_data     TX FIFO head byte (0 when empty)
//   tx_valid    TX FIFO non-empty
//   tx_ready    downstream accept; pop on tx_valid && tx_ready
//   timer_irq   level copy of STATUS.match (only with MEM_IO_TIMER_EN)
// Map: RAM words at 0x0000_0000 + 4*i; I/O registers at 0x8000_0000..10.
// Every cycle presents an address, so a cycle on an unmapped address,
// read or write, sets the sticky bus_err.
// Build option: define MEM_IO_TIMER_EN to include the timer, TIMER_CMP,
// STATUS.match and the timer_irq port.
// ----------------------------------------------------------------------------
module mem_io_bus #(
    parameter int    RAM_AW     = 10,
    parameter int    FIFO_DEPTH = 16,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    input  logic        Mem_Write,
    output logic [31:0] Read_Data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
`ifdef MEM_IO_TIMER_EN
    output logic        timer_irq,
`endif
    input  logic        tx_ready
);

    import mem_io_bus_pkg::*;

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- address decode ----------------
    logic              w_ram_hit;
    logic [RAM_AW-1:0] w_ram_idx;
    io_sel_t           w_io_sel;
    logic              w_unmapped;
    logic              w_unused_addr_bits;

    // RAM hits only in the low window; higher addresses with Address[31]=0
    // would alias the array and are treated as unmapped instead.
    assign w_ram_hit = !Address[31] && (Address[30:RAM_AW+2] == '0);
    assign w_ram_idx = Address[RAM_AW+1:2];
    assign w_io_sel  = Address[31] ? io_decode(Address[31:2]) : IO_UNMAPPED;
    assign w_unmapped = !w_ram_hit && (w_io_sel == IO_UNMAPPED);
    assign w_unused_addr_bits = ^Address[1:0];

    logic w_wr_ram;
    logic w_push;
    logic w_wr_clr;

    assign w_wr_ram = Mem_Write && w_ram_hit;
    assign w_push   = Mem_Write && (w_io_sel == IO_TX_DATA);
    assign w_wr_clr = Mem_Write && (w_io_sel == IO_CLR);

    // ---------------- RAM (not reset) ----------------
    logic [31:0] r_ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= Write_Data;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]     w_fifo_data;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [FCW-1:0] w_fifo_count;
    logic           w_pop;

    mem_io_bus_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (Write_Data[7:0]),
        .i_pop   (tx_ready),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign tx_data  = w_fifo_data;
    assign tx_valid = !w_fifo_empty;
    assign w_pop    = tx_valid && tx_ready;

    // ---------------- sticky flags (set wins over clear) ----------------
    logic r_tx_ovf;
    logic r_bus_err;
    logic w_ovf_set;

    // A push into a full FIFO is only lost when nothing drains that cycle.
    assign w_ovf_set = w_push && w_fifo_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_ovf  <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_tx_ovf  <= w_ovf_set  | (r_tx_ovf  & ~(w_wr_clr & Write_Data[CLR_TX_OVF]));
            r_bus_err <= w_unmapped | (r_bus_err & ~(w_wr_clr & Write_Data[CLR_BUS_ERR]));
        end
    end

    // ---------------- timer ----------------
    logic        w_match;
    logic [31:0] w_cnt_rd;
    logic [31:0] w_cmp_rd;

`ifdef MEM_IO_TIMER_EN
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic        r_match;
    logic        w_wr_cmp;

    assign w_wr_cmp = Mem_Write && (w_io_sel == IO_TIMER_CMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_cmp   <= TIMER_CMP_RST;
            r_match <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_wr_cmp) begin
                r_cmp <= Write_Data;
            end
            // Registered compare: match is visible the cycle after equality.
            r_match <= (r_cnt == r_cmp) | (r_match & ~(w_wr_clr & Write_Data[CLR_MATCH]));
        end
    end

    assign w_match   = r_match;
    assign w_cnt_rd  = r_cnt;
    assign w_cmp_rd  = r_cmp;
    assign timer_irq = r_match;
`else
    assign w_match  = 1'b0;
    assign w_cnt_rd = '0;
    assign w_cmp_rd = '0;
`endif

    // ---------------- STATUS and read mux ----------------
    logic [31:0] w_status;

    always_comb begin
        w_status              = '0;
        w_status[ST_FULL]     = w_fifo_full;
        w_status[ST_EMPTY]    = w_fifo_empty;
        w_status[ST_MATCH]    = w_match;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[ST_BUS_ERR]  = r_bus_err;
        w_status[15:8]        = 8'(w_fifo_count);
    end

    always_comb begin
        Read_Data = '0;
        if (w_ram_hit) begin
            Read_Data = r_ram[w_ram_idx];
        end else begin
            case (w_io_sel)
                IO_TIMER_CNT: Read_Data = w_cnt_rd;
                IO_TIMER_CMP: Read_Data = w_cmp_rd;
                IO_STATUS:    Read_Data = w_status;
                default:      Read_Data = '0;   // TX_DATA, CLR, unmapped
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bus.sv
module tb_mem_io_bus;

    localparam int RAM_AW     = 10;
    localparam int FIFO_DEPTH = 16;

    localparam logic [31:0] A_CNT    = 32'h8000_0000;
    localparam logic [31:0] A_CMP    = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_TX     = 32'h8000_000C;
    localparam logic [31:0] A_CLR    = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Write_Data = 32'h0;
    logic        Mem_Write = 1'b0;
    logic [31:0] Read_Data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
`ifdef MEM_IO_TIMER_EN
    logic        timer_irq;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    mem_io_bus #(
        .RAM_AW     (RAM_AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Mem_Write  (Mem_Write),
        .Read_Data  (Read_Data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
`ifdef MEM_IO_TIMER_EN
        .timer_irq  (timer_irq),
`endif
        .tx_ready   (tx_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address    = a;
        Write_Data = d;
        Mem_Write  = 1'b1;
        @(negedge clk);
        Mem_Write  = 1'b0;
        Address    = 32'h0;
        Write_Data = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Address   = a;
        Mem_Write = 1'b0;
        #1;
        d = Read_Data;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_write(A_TX, {24'h0, b});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({tx_valid, tx_data} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h expected valid=0 data=00", tx_valid, tx_data);
        end
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL reset_status: got %h expected %h", d, 32'h2);
        end
`ifdef MEM_IO_TIMER_EN
        bus_read(A_CMP, d);
        n_vec++;
        if (d !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_cmp: got %h expected ffffffff", d);
        end
`endif
    endtask

    task automatic test_ram();
        logic [31:0] d;
        bus_write(32'h0000_0010, 32'h1234_5678);
        bus_read(32'h0000_0010, d);
        n_vec++;
        if (d !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL ram_rw: got %h expected 12345678", d);
        end
        // read in the write cycle returns the old word
        @(negedge clk);
        Address = 32'h0000_0010; Write_Data = 32'hCAFE_F00D; Mem_Write = 1'b1;
        #1;
        n_vec++;
        if (Read_Data !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL ram_old_on_write: got %h expected 12345678", Read_Data);
        end
        @(negedge clk);
        Mem_Write = 1'b0;
        #1;
        n_vec++;
        if (Read_Data !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL ram_new_after_write: got %h expected cafef00d", Read_Data);
        end
        bus_read(32'h0000_0013, d);
        n_vec++;
        if (d !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL ram_low_bits_ignored: got %h expected cafef00d", d);
        end
        bus_write(32'h0000_0FFC, 32'hA5A5_0001);
        bus_read(32'h0000_0FFC, d);
        n_vec++;
        if (d !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL ram_top_word: got %h expected a5a50001", d);
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL ram_no_bus_err: got %h expected 00000002", d);
        end
    endtask

    task automatic test_fifo_basic();
        logic [31:0] d;
        logic [7:0]  e;
        tx_ready = 1'b0;
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0300) begin
            n_err++;
            $display("FAIL fifo_count3: got %h expected 00000300", d);
        end
        @(negedge clk);
        Address  = 32'h0;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({tx_valid, tx_data} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL fifo_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, e);
            end
            @(negedge clk);
        end
        #1;
        n_vec++;
        if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fifo_drained_valid: got %b expected 0", tx_valid);
        end
        tx_ready = 1'b0;
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL fifo_empty_status: got %h expected 00000002", d);
        end
    endtask

    task automatic test_overflow_and_full_pushpop();
        logic [31:0] d;
        logic [7:0]  e;
        tx_ready = 1'b0;
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
            push_byte(8'(i));
            if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_1009) begin
            n_err++;
            $display("FAIL ovf_status: got %h expected 00001009", d);
        end
        bus_write(A_CLR, 32'h8);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_1001) begin
            n_err++;
            $display("FAIL ovf_clear: got %h expected 00001001", d);
        end
        // full FIFO: push 0x55 while popping in the same cycle
        @(negedge clk);
        Address = A_TX; Write_Data = 32'h55; Mem_Write = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        Mem_Write = 1'b0; Address = 32'h0; tx_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_1001) begin
            n_err++;
            $display("FAIL full_pushpop_status: got %h expected 00001001", d);
        end
        @(negedge clk);
        Address  = 32'h0;
        tx_ready = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({tx_valid, tx_data} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, e);
            end
            @(negedge clk);
        end
        #1;
        n_vec++;
        if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_drain_end: got valid=%b expected 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  e;
        // one entry, push and pop together: head becomes the new byte
        push_byte(8'hA0);
        @(negedge clk);
        Address = A_TX; Write_Data = 32'hB0; Mem_Write = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        Mem_Write = 1'b0; Address = 32'h0; tx_ready = 1'b0;
        #1;
        n_vec++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hB0}) begin
            n_err++;
            $display("FAIL one_entry_pushpop: got valid=%b data=%h expected valid=1 data=b0", tx_valid, tx_data);
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL one_entry_count: got %h expected 00000100", d);
        end
        @(negedge clk);
        Address = 32'h0; tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        // consecutive-cycle pushes with Mem_Write held high
        @(negedge clk);
        Address = A_TX; Mem_Write = 1'b1; Write_Data = 32'h61;
        @(negedge clk);
        Write_Data = 32'h62;
        @(negedge clk);
        Write_Data = 32'h63;
        @(negedge clk);
        Mem_Write = 1'b0; Address = 32'h0;
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0300) begin
            n_err++;
            $display("FAIL b2b_count: got %h expected 00000300", d);
        end
        @(negedge clk);
        Address = 32'h0; tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({tx_valid, tx_data} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL b2b_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, e);
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_bus_err();
        logic [31:0] d;
        bus_read(A_TX, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL txdata_read: got %h expected 00000000", d);
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL txdata_read_no_err: got %h expected 00000002", d);
        end
        bus_read(32'h4000_0000, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read: got %h expected 00000000", d);
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0012) begin
            n_err++;
            $display("FAIL unmapped_read_err: got %h expected 00000012", d);
        end
        bus_write(A_CLR, 32'h10);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL bus_err_clear: got %h expected 00000002", d);
        end
        // write just above RAM must not alias onto word 0
        bus_write(32'h0000_0000, 32'h1111_2222);
        bus_write(32'h0000_1000, 32'hDEAD_BEEF);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0012) begin
            n_err++;
            $display("FAIL alias_write_err: got %h expected 00000012", d);
        end
        bus_read(32'h0000_0000, d);
        n_vec++;
        if (d !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL alias_write_ignored: got %h expected 11112222", d);
        end
        bus_write(A_CLR, 32'h10);
        bus_read(32'h8000_0014, d);
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0012) begin
            n_err++;
            $display("FAIL io_hole_err: got %h expected 00000012", d);
        end
        bus_write(A_CLR, 32'h10);
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] d;
        tx_ready = 1'b0;
        push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
        @(negedge clk);
        Address = 32'h0; tx_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h72}) begin
            n_err++;
            $display("FAIL mid_drain_head: got valid=%b data=%h expected valid=1 data=72", tx_valid, tx_data);
        end
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({tx_valid, tx_data} !== 9'h000) begin
            n_err++;
            $display("FAIL async_flush: got valid=%b data=%h expected valid=0 data=00", tx_valid, tx_data);
        end
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL post_reset_status: got %h expected 00000002", d);
        end
        bus_read(32'h0000_0000, d);
        n_vec++;
        if (d !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL ram_kept_over_reset: got %h expected 11112222", d);
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
`ifdef MEM_IO_TIMER_EN
        logic        found;
        logic [31:0] cnt_at;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        Address = A_CMP; Write_Data = 32'd20; Mem_Write = 1'b1;
        @(negedge clk);
        Mem_Write = 1'b0; Address = A_CNT;
        found = 1'b0; cnt_at = 32'h0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #1;
            if (timer_irq === 1'b1) begin
                found  = 1'b1;
                cnt_at = Read_Data;
            end
        end
        n_vec++;
        if (!found || cnt_at !== 32'd21) begin
            n_err++;
            $display("FAIL irq_rise: got found=%b cnt=%0d expected found=1 cnt=21", found, cnt_at);
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0006) begin
            n_err++;
            $display("FAIL match_status: got %h expected 00000006", d);
        end
        bus_write(A_CLR, 32'h4);
        #1;
        n_vec++;
        if (timer_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: got %b expected 0", timer_irq);
        end
        bus_write(A_CNT, 32'h0);
        bus_read(A_CNT, d);
        n_vec++;
        if (d < 32'd25 || d > 32'd200) begin
            n_err++;
            $display("FAIL cnt_not_writable: got %0d expected between 25 and 200", d);
        end
        bus_write(A_CMP, 32'd200);
        @(negedge clk);
        Address = A_CNT;
        found = 1'b0; cnt_at = 32'h0;
        for (int i = 0; i < 250 && !found; i++) begin
            @(negedge clk);
            #1;
            if (timer_irq === 1'b1) begin
                found  = 1'b1;
                cnt_at = Read_Data;
            end
        end
        n_vec++;
        if (!found || cnt_at !== 32'd201) begin
            n_err++;
            $display("FAIL irq_reassert: got found=%b cnt=%0d expected found=1 cnt=201", found, cnt_at);
        end
        bus_write(A_CLR, 32'h4);
`else
        bus_write(A_CMP, 32'd5);
        bus_read(A_CMP, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL no_timer_cmp: got %h expected 00000000", d);
        end
        bus_read(A_CNT, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL no_timer_cnt: got %h expected 00000000", d);
        end
        bus_read(A_STATUS, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL no_timer_status: got %h expected 00000002", d);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ram();
        test_fifo_basic();
        test_overflow_and_full_pushpop();
        test_back_to_back();
        test_bus_err();
        test_reset_mid_drain();
        test_timer();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
